ripple_borrow_subtractor: RTL and testbench
===========================================

# ripple_borrow_subtractor

Registered WIDTH-bit unsigned subtractor built as a chain of 1-bit full-subtractor cells, each passing its borrow to the next. It computes diff = a − b − bin with a borrow-out, and serves as the arithmetic leaf for datapath blocks that need a clocked difference with an explicit borrow chain. Results are registered, with a one-cycle latency and a valid strobe.

## Interface
- WIDTH, 4: operand and result width in bits, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid; sampled at the clk rising edge.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in to bit 0.
- out_valid  output  1  one-cycle strobe marking a new result.
- diff  output  WIDTH  registered difference.
- bor  output  1  registered borrow-out from the MSB cell.
- ovf  output  1  registered signed-overflow flag. Present only with RIPPLE_BORROW_OVF_EN.
- Reset is asynchronous and active-low (rst_n), on the single clock clk.

## Operation
- The borrow chain is built from explicit cells: b0 = bin. For each bit i:
  - d[i] = a[i] ^ b[i] ^ b_i
  - b_{i+1} = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & b_i)
- Borrow-out is bor = b_WIDTH.
- The result equals {bor, diff} = a − b − bin computed over WIDTH+1 bits (two's complement):
  - diff = (a − b − bin) mod 2^WIDTH.
  - bor = 1 exactly when a < b + bin (unsigned compare).
- Operands are unsigned. No saturation is applied; the result wraps.
- The chain is purely combinational. Only the output stage is registered.
- When in_valid = 0, diff, bor and ovf hold their last values.
- No back-pressure: a new operand set may be accepted every cycle.

## Timing
- Reset values: out_valid = 0, diff = 0, bor = 0, ovf = 0.
- Assertion of rst_n clears all outputs immediately, without waiting for a clock edge.
- Rising edge with in_valid = 1: diff and bor load the result of that edge's a, b and bin. out_valid = 1 for exactly the following cycle.
- Latency is 1 cycle from input sample to output. Throughput is 1 result per cycle.
- Back-to-back in_valid: out_valid stays high and diff/bor update every cycle.
- Reset asserted mid-stream: any result in flight is discarded. The first result after rst_n deasserts needs a fresh in_valid.
- Deassertion of rst_n is treated as synchronous to clk by the surrounding reset synchroniser.
- Inputs must be stable in the setup/hold window only. The full WIDTH-stage ripple path is the critical path and must close in one clk period.

## Configuration
- RIPPLE_BORROW_OVF_EN defined:
  - The ovf port exists.
  - ovf registers (borrow into MSB cell) XOR (borrow out of MSB cell).
  - ovf flags signed two's-complement overflow of a − b − bin.
  - ovf is updated under the same in_valid/reset rules as diff.
- RIPPLE_BORROW_OVF_EN undefined:
  - The ovf port and its register are omitted.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst_n low mid-cycle -> diff = 0, bor = 0, out_valid = 0 (and ovf = 0) immediately.
- WIDTH = 4, a = 0001, b = 1000, bin = 0, in_valid = 1 -> next cycle diff = 1001, bor = 1, ovf = 1.
- a = 0011, b = 1100, bin = 1 -> diff = 0110, bor = 1, ovf = 0.
- a = 0111, b = 1110, bin = 0 -> diff = 1001, bor = 1, ovf = 1.
- a = 1111, b = 1111, bin = 1 -> diff = 1111, bor = 1, ovf = 0.
- Boundaries:
  - a = 1000, b = 0000, bin = 1 -> diff = 0111, bor = 0, ovf = 1.
  - a = 0101, b = 0101, bin = 0 -> diff = 0000, bor = 0.
- Hold: in_valid = 0 for 3 cycles after a result -> outputs unchanged, out_valid = 0.
- Back-to-back: two consecutive in_valid cycles -> out_valid high for 2 cycles with the matching results.
- Exhaustive: all 512 {a, b, bin} combinations at WIDTH = 4 -> match {bor, diff} = a − b − bin.

Source files
------------

// File: rtl/ripple_borrow_subtractor.sv
// Registered WIDTH-bit unsigned subtractor built from a chain of 1-bit full-subtractor cells.
// Optional signed-overflow output is enabled by defining RIPPLE_BORROW_OVF_EN.

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // One bit of a - b - borrow, producing the borrow for the next cell
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

module ripple_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bor
`ifdef RIPPLE_BORROW_OVF_EN
  ,
  output logic             ovf
`endif
);

  // borrow_s[i] is the borrow into cell i; borrow_s[WIDTH] leaves the MSB cell
  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] diff_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bor_r;

  assign borrow_s[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .x  (a[i]),
      .y  (b[i]),
      .bi (borrow_s[i]),
      .d  (diff_s[i]),
      .bo (borrow_s[i+1])
    );
  end

  // Output stage: strobe follows in_valid, result loads only on valid operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      bor_r       <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        diff_r <= diff_s;
        bor_r  <= borrow_s[WIDTH];
      end else begin
        diff_r <= diff_r;
        bor_r  <= bor_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bor       = bor_r;

`ifdef RIPPLE_BORROW_OVF_EN
  logic ovf_s;
  logic ovf_r;

  // Signed overflow shows up as disagreement between borrow into and out of the MSB cell
  always_comb begin
    ovf_s = borrow_s[WIDTH-1] ^ borrow_s[WIDTH];
  end

  // Overflow register shares the load and reset rules of the difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (in_valid) begin
      ovf_r <= ovf_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// Self-checking bench for ripple_borrow_subtractor at WIDTH = 4 (ovf checks when RIPPLE_BORROW_OVF_EN is defined).

module tb_ripple_borrow_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             bor;
`ifdef RIPPLE_BORROW_OVF_EN
  logic             ovf;
`endif

  int checks;
  int errors;

  ripple_borrow_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .diff      (diff),
    .bor       (bor)
`ifdef RIPPLE_BORROW_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vbin, input logic vv);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = vv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || diff !== 4'd0 || bor !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: out_valid=%b diff=%b bor=%b, want 0/0000/0", out_valid, diff, bor);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Load a nonzero result, then reset mid-cycle while another result is in flight
    drive(4'b0001, 4'b1000, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0011, 4'b1100, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 4'd0 || bor !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b diff=%b bor=%b, want 0/0000/0", out_valid, diff, bor);
    end
`ifdef RIPPLE_BORROW_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
    end
`endif
    @(negedge clk);
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || diff !== 4'd0 || bor !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid=%b diff=%b bor=%b, want 0/0000/0", out_valid, diff, bor);
    end
  endtask

  task automatic test_directed();
    logic [3:0] va [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1000, 4'b0101};
    logic [3:0] vb [6] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b0101};
    logic       vc [6] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
    logic [3:0] ed [6] = '{4'b1001, 4'b0110, 4'b1001, 4'b1111, 4'b0111, 4'b0000};
    logic       eb [6] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
    logic       eo [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(4'd0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || diff !== ed[i] || bor !== eb[i]) begin
        errors++;
        $display("FAIL directed_%0d: out_valid=%b diff=%b bor=%b, want 1/%b/%b", i, out_valid, diff, bor, ed[i], eb[i]);
      end
`ifdef RIPPLE_BORROW_OVF_EN
      checks++;
      if (ovf !== eo[i]) begin
        errors++;
        $display("FAIL directed_ovf_%0d: ovf=%b, want %b", i, ovf, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unreachable");
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    drive(4'b0111, 4'b1110, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 3), 4'(i), 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || diff !== 4'b1001 || bor !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b diff=%b bor=%b, want 0/1001/1", i, out_valid, diff, bor);
      end
`ifdef RIPPLE_BORROW_OVF_EN
      checks++;
      if (ovf !== 1'b1) begin
        errors++;
        $display("FAIL hold_ovf_%0d: ovf=%b, want 1", i, ovf);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    drive(4'b1010, 4'b0011, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || diff !== 4'b0111 || bor !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: out_valid=%b diff=%b bor=%b, want 1/0111/0", out_valid, diff, bor);
    end
    drive(4'b0010, 4'b0100, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || diff !== 4'b1101 || bor !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: out_valid=%b diff=%b bor=%b, want 1/1101/1", out_valid, diff, bor);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_strobe_end: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] exp_full;
    int         sa, sb, sr;
    logic       exp_ovf;
    for (int i = 0; i < 512; i++) begin
      drive(4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1);
      exp_full = {1'b0, a} - {1'b0, b} - {4'd0, bin};
      sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      sr = sa - sb - int'(bin);
      exp_ovf = (sr < -8 || sr > 7) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {bor, diff} !== exp_full) begin
        errors++;
        $display("FAIL exhaustive a=%b b=%b bin=%b: got %b%b valid=%b, want %b", a, b, bin, bor, diff, out_valid, exp_full);
      end
`ifdef RIPPLE_BORROW_OVF_EN
      checks++;
      if (ovf !== exp_ovf) begin
        errors++;
        $display("FAIL exhaustive_ovf a=%b b=%b bin=%b: ovf=%b, want %b", a, b, bin, ovf, exp_ovf);
      end
`endif
    end
    drive(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_exhaustive();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
